// File: rtl/bids22_log_pkg.sv
// Shared types for the Bids22 round logger: winner codes and the FIFO record.
package bids22_log_pkg;

    localparam int AMT_W = 32;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        X    = 2'b01,
        Y    = 2'b10,
        Z    = 2'b11
    } winner_e;

    typedef struct packed {
        winner_e            winner;
        logic [AMT_W-1:0]   amount;
    } round_rec_t;

    // Exactly one win line gives that bidder; zero or several give NONE.
    function automatic winner_e encode_winner(input logic x, input logic y, input logic z);
        winner_e w;
        case ({x, y, z})
            3'b100:  w = X;
            3'b010:  w = Y;
            3'b001:  w = Z;
            default: w = NONE;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/bids22_rec_fifo.sv
// Synchronous record FIFO. Pointers carry one extra bit so that full and
// empty are distinguished without a separate flag. No fall-through: a push
// into an empty FIFO becomes visible on the head the following cycle.
module bids22_rec_fifo
    import bids22_log_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  round_rec_t               push_rec,
    input  logic                     pop,
    input  logic                     clear,
    output round_rec_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    round_rec_t  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    // A pop frees the slot the coinciding push needs, so full+pop+push is legal.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        count   = wr_ptr - rd_ptr;
        empty   = (wr_ptr == rd_ptr);
        full    = (count == DEPTH_P);
        head    = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    // Pointer update; clear dominates any push or pop in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Record storage; contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_rec;
    end

endmodule

// File: rtl/bids22_round_log.sv
// Observer for the Bids22 auction core: turns each rising edge of roundOver
// into a {winner, amount} record, keeps saturating statistics and sticky
// error flags. Nothing here drives the auction core.
//
// Read handshake: rd_valid marks a valid head (rd_winner/rd_amount); the
// record is consumed on a cycle where rd_valid && rd_ready at the rising clock
// edge. rd_valid does not depend on rd_ready, and once high it stays high
// until the head is consumed or the logger is cleared/reset.
module bids22_round_log
    import bids22_log_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 40
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     roundOver,
    input  logic                     X_win,
    input  logic                     Y_win,
    input  logic                     Z_win,
    input  logic [31:0]              maxBid,
    input  logic                     clear,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [1:0]               rd_winner,
    output logic [31:0]              rd_amount,
    output logic [$clog2(DEPTH):0]   rd_count,
    output logic [CNT_W-1:0]         x_wins,
    output logic [CNT_W-1:0]         y_wins,
    output logic [CNT_W-1:0]         z_wins,
    output logic [CNT_W-1:0]         rounds,
    output logic [ACC_W-1:0]         revenue,
    output logic [7:0]               overflow_cnt,
    output logic                     multi_win_err
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       OVF_ONE = 8'd1;

    logic         round_over_q;
    logic         capture;
    logic         multi_hit;
    winner_e      cap_winner;
    logic [31:0]  cap_amount;
    round_rec_t   cap_rec;
    round_rec_t   head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    logic [ACC_W:0] rev_sum;

    // Capture on a 0->1 edge of roundOver; a clear in the same cycle eats it.
    always_comb begin
        capture    = roundOver && !round_over_q && !clear;
        multi_hit  = (X_win && Y_win) || (X_win && Z_win) || (Y_win && Z_win);
        cap_winner = encode_winner(X_win, Y_win, Z_win);
        cap_amount = (cap_winner == NONE) ? 32'd0 : maxBid;
        cap_rec    = '{winner: cap_winner, amount: cap_amount};
        pop        = rd_valid && rd_ready;
        rev_sum    = {1'b0, revenue} + (ACC_W+1)'(cap_amount);
        rd_valid   = !fifo_empty;
        rd_winner  = head.winner;
        rd_amount  = head.amount;
    end

    // Previous-cycle roundOver. Resets high so a level already present at
    // reset release is not mistaken for a new round; clear leaves it alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) round_over_q <= 1'b1;
        else          round_over_q <= roundOver;
    end

    // Statistics: every capture counts, even if its record gets dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_wins        <= '0;
            y_wins        <= '0;
            z_wins        <= '0;
            rounds        <= '0;
            revenue       <= '0;
            overflow_cnt  <= '0;
            multi_win_err <= 1'b0;
        end else if (clear) begin
            x_wins        <= '0;
            y_wins        <= '0;
            z_wins        <= '0;
            rounds        <= '0;
            revenue       <= '0;
            overflow_cnt  <= '0;
            multi_win_err <= 1'b0;
        end else if (capture) begin
            if (rounds != '1) rounds <= rounds + CNT_ONE;
            if (cap_winner == X && x_wins != '1) x_wins <= x_wins + CNT_ONE;
            if (cap_winner == Y && y_wins != '1) y_wins <= y_wins + CNT_ONE;
            if (cap_winner == Z && z_wins != '1) z_wins <= z_wins + CNT_ONE;
            revenue <= rev_sum[ACC_W] ? '1 : rev_sum[ACC_W-1:0];
            if (multi_hit) multi_win_err <= 1'b1;
            if (fifo_full && !pop && overflow_cnt != 8'hFF)
                overflow_cnt <= overflow_cnt + OVF_ONE;
        end
    end

    bids22_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (capture),
        .push_rec (cap_rec),
        .pop      (pop),
        .clear    (clear),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (rd_count)
    );

endmodule

// File: tb/tb_bids22_round_log.sv
// Bench for bids22_round_log: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_bids22_round_log;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int ACC_W = 40;
    localparam int CW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset / stimulus signals
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic roundOver = 1'b0;
    logic X_win = 1'b0, Y_win = 1'b0, Z_win = 1'b0;
    logic [31:0] maxBid = '0;
    logic clear = 1'b0;
    logic rd_ready = 1'b0;

    always #5 clk = ~clk;

    // ---------------- DUT (40-bit revenue)
    logic             rd_valid;
    logic [1:0]       rd_winner;
    logic [31:0]      rd_amount;
    logic [CW-1:0]    rd_count;
    logic [CNT_W-1:0] x_wins, y_wins, z_wins, rounds;
    logic [ACC_W-1:0] revenue;
    logic [7:0]       overflow_cnt;
    logic             multi_win_err;

    bids22_round_log #(.DEPTH(DEPTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset_n(reset_n), .roundOver(roundOver),
        .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win), .maxBid(maxBid),
        .clear(clear), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_winner(rd_winner), .rd_amount(rd_amount), .rd_count(rd_count),
        .x_wins(x_wins), .y_wins(y_wins), .z_wins(z_wins), .rounds(rounds),
        .revenue(revenue), .overflow_cnt(overflow_cnt), .multi_win_err(multi_win_err)
    );

    // ---------------- second DUT with a 32-bit accumulator for saturation
    logic             s_rd_valid;
    logic [1:0]       s_rd_winner;
    logic [31:0]      s_rd_amount;
    logic [CW-1:0]    s_rd_count;
    logic [CNT_W-1:0] s_x_wins, s_y_wins, s_z_wins, s_rounds;
    logic [31:0]      s_revenue;
    logic [7:0]       s_overflow_cnt;
    logic             s_multi_win_err;

    bids22_round_log #(.DEPTH(DEPTH), .CNT_W(CNT_W), .ACC_W(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .roundOver(roundOver),
        .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win), .maxBid(maxBid),
        .clear(clear), .rd_valid(s_rd_valid), .rd_ready(rd_ready),
        .rd_winner(s_rd_winner), .rd_amount(s_rd_amount), .rd_count(s_rd_count),
        .x_wins(s_x_wins), .y_wins(s_y_wins), .z_wins(s_z_wins), .rounds(s_rounds),
        .revenue(s_revenue), .overflow_cnt(s_overflow_cnt), .multi_win_err(s_multi_win_err)
    );

    // ---------------- reference model
    logic [33:0] exp_q[$];   // {winner, amount}
    int      m_x, m_y, m_z, m_rounds, m_ovf;
    bit      m_multi;
    longint  m_rev40, m_rev32;
    bit      m_ro_prev;
    int      checks = 0;
    int      errors = 0;

    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;
    localparam longint R40_MAX = (64'd1 << 40) - 1;
    localparam longint R32_MAX = (64'd1 << 32) - 1;

    task automatic model_reset();
        exp_q.delete();
        m_x = 0; m_y = 0; m_z = 0; m_rounds = 0; m_ovf = 0;
        m_multi = 0; m_rev40 = 0; m_rev32 = 0;
        m_ro_prev = 1;
    endtask

    // Apply one rising clock edge to the model using the inputs held now.
    task automatic model_clock();
        bit cap, pop;
        int nwin;
        logic [1:0] code;
        logic [31:0] amt;
        cap = roundOver && !m_ro_prev && !clear;
        pop = (exp_q.size() > 0) && rd_ready;
        m_ro_prev = roundOver;
        if (clear) begin
            exp_q.delete();
            m_x = 0; m_y = 0; m_z = 0; m_rounds = 0; m_ovf = 0;
            m_multi = 0; m_rev40 = 0; m_rev32 = 0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (cap) begin
                nwin = int'(X_win) + int'(Y_win) + int'(Z_win);
                if (nwin != 1)  code = 2'd0;
                else if (X_win) code = 2'd1;
                else if (Y_win) code = 2'd2;
                else            code = 2'd3;
                amt = (code == 2'd0) ? 32'd0 : maxBid;
                if (nwin > 1) m_multi = 1;
                if (m_rounds < CNT_MAX) m_rounds++;
                if (code == 2'd1 && m_x < CNT_MAX) m_x++;
                if (code == 2'd2 && m_y < CNT_MAX) m_y++;
                if (code == 2'd3 && m_z < CNT_MAX) m_z++;
                m_rev40 = (m_rev40 + longint'(amt) > R40_MAX) ? R40_MAX : m_rev40 + longint'(amt);
                m_rev32 = (m_rev32 + longint'(amt) > R32_MAX) ? R32_MAX : m_rev32 + longint'(amt);
                if (exp_q.size() < DEPTH) exp_q.push_back({code, amt});
                else if (m_ovf < 255) m_ovf++;
            end
        end
    endtask

    // ---------------- scoreboard
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [63:0] hw, ha;
        chk("rd_valid",      64'(rd_valid),      64'(exp_q.size() > 0));
        chk("rd_count",      64'(rd_count),      64'(exp_q.size()));
        if (exp_q.size() > 0) begin
            hw = 64'(exp_q[0][33:32]);
            ha = 64'(exp_q[0][31:0]);
            chk("rd_winner",   64'(rd_winner),   hw);
            chk("rd_amount",   64'(rd_amount),   ha);
            chk("s_rd_winner", 64'(s_rd_winner), hw);
            chk("s_rd_amount", 64'(s_rd_amount), ha);
        end
        chk("x_wins",        64'(x_wins),        64'(m_x));
        chk("y_wins",        64'(y_wins),        64'(m_y));
        chk("z_wins",        64'(z_wins),        64'(m_z));
        chk("rounds",        64'(rounds),        64'(m_rounds));
        chk("revenue40",     64'(revenue),       64'(m_rev40));
        chk("overflow_cnt",  64'(overflow_cnt),  64'(m_ovf));
        chk("multi_win_err", 64'(multi_win_err), 64'(m_multi));
        chk("revenue32",     64'(s_revenue),     64'(m_rev32));
        chk("s_rd_valid",    64'(s_rd_valid),    64'(exp_q.size() > 0));
        chk("s_rd_count",    64'(s_rd_count),    64'(exp_q.size()));
        chk("s_x_wins",      64'(s_x_wins),      64'(m_x));
        chk("s_y_wins",      64'(s_y_wins),      64'(m_y));
        chk("s_z_wins",      64'(s_z_wins),      64'(m_z));
        chk("s_rounds",      64'(s_rounds),      64'(m_rounds));
        chk("s_overflow",    64'(s_overflow_cnt), 64'(m_ovf));
        chk("s_multi",       64'(s_multi_win_err), 64'(m_multi));
    endtask

    // ---------------- driver tasks (entered and left at posedge + 1)
    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic capture(input logic x, input logic y, input logic z, input logic [31:0] bid);
        X_win = x; Y_win = y; Z_win = z; maxBid = bid;
        roundOver = 1'b1;
        tick();
        roundOver = 1'b0; X_win = 0; Y_win = 0; Z_win = 0;
        tick();
    endtask

    task automatic rand_single_capture();
        int w;
        w = $urandom_range(0, 2);
        capture(w == 0, w == 1, w == 2, $urandom);
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        repeat (n) tick();
        rd_ready = 1'b0;
    endtask

    // ---------------- directed then random sequence
    initial begin
        model_reset();
        #1;
        check_all();                       // reset values
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        tick();

        // Single X win, then pop.
        capture(1, 0, 0, 32'd100);
        drain(1);
        tick();

        // Level held 5 cycles -> one record; then a no-sale round.
        Y_win = 1; maxBid = 32'd7; roundOver = 1'b1;
        repeat (5) tick();
        roundOver = 1'b0; Y_win = 0;
        tick();
        capture(0, 0, 0, 32'd55);

        // Multiple winners -> NONE record, sticky error until clear.
        capture(1, 0, 1, 32'd77);
        capture(0, 0, 1, 32'd9);
        drain(5);
        clear = 1'b1; tick(); clear = 1'b0; tick();

        // Overflow: 10 captures into depth 8, then drain in order.
        repeat (10) rand_single_capture();
        drain(10);

        // Full FIFO with push and pop in the same cycle.
        repeat (8) rand_single_capture();
        X_win = 1; maxBid = 32'h1234; rd_ready = 1'b1; roundOver = 1'b1;
        tick();
        rd_ready = 1'b0; roundOver = 1'b0; X_win = 0;
        tick();

        // Clear coinciding with a capture; held level afterwards is not a new edge.
        Z_win = 1; maxBid = 32'd500; clear = 1'b1; roundOver = 1'b1;
        tick();
        clear = 1'b0;
        tick(); tick();
        roundOver = 1'b0; Z_win = 0;
        tick();

        // Revenue saturation on the 32-bit accumulator.
        capture(1, 0, 0, 32'd100);
        capture(0, 1, 0, 32'hFFFF_FFFF);
        capture(0, 0, 1, 32'd5);
        drain(4);

        // Asynchronous reset with records pending.
        capture(1, 0, 0, 32'd11);
        capture(0, 1, 0, 32'd22);
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        @(posedge clk); #1;
        check_all();
        reset_n = 1'b1;
        tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int w;
            w = $urandom_range(0, 9);
            X_win = (w < 3) || (w == 9);
            Y_win = (w >= 3 && w < 6);
            Z_win = (w >= 6 && w < 8) || (w == 9);
            maxBid = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            roundOver = $urandom_range(0, 1);
            rd_ready = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 59) == 0);
            tick();
        end
        clear = 1'b0; rd_ready = 1'b0; roundOver = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
